// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter: FSM states, owner ids
// and the wait-state counter width.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the arbiter: CPU and EXT requester ports plus the memory side.
// Handshake: a requester raises req with we/adr/wd and holds req until its ready
// pulses for one cycle; rd is valid during that ready cycle. Request fields are
// captured when the access is granted and ignored afterwards.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_adr;
    logic [DW-1:0] cpu_wd;
    logic [DW-1:0] cpu_rd;
    logic          cpu_ready;

    logic          ext_req;
    logic          ext_we;
    logic [AW-1:0] ext_adr;
    logic [DW-1:0] ext_wd;
    logic [DW-1:0] ext_rd;
    logic          ext_ready;

    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wd;
    logic          mem_we;
    logic [DW-1:0] mem_rd;

    logic          grant_ext;

    modport slave (
        input  cpu_req, cpu_we, cpu_adr, cpu_wd,
        input  ext_req, ext_we, ext_adr, ext_wd,
        input  mem_rd,
        output cpu_rd, cpu_ready, ext_rd, ext_ready,
        output mem_adr, mem_wd, mem_we, grant_ext
    );

    modport master (
        output cpu_req, cpu_we, cpu_adr, cpu_wd,
        output ext_req, ext_we, ext_adr, ext_wd,
        output mem_rd,
        input  cpu_rd, cpu_ready, ext_rd, ext_ready,
        input  mem_adr, mem_wd, mem_we, grant_ext
    );

endinterface

// File: rtl/mem_port_arbiter_pick2.sv
// Combinational two-way picker: chooses the requester to serve from the IDLE
// request vector, either fixed CPU priority or alternating on ties.
module arb_pick2
    import arb_pkg::*;
#(
    parameter int CPU_PRIO = 0
) (
    input  logic [1:0] req,         // [0] = CPU, [1] = EXT
    input  owner_t     last_owner,
    output owner_t     winner
);

    always_comb begin
        winner = OWN_CPU;
        case (req)
            2'b01:   winner = OWN_CPU;
            2'b10:   winner = OWN_EXT;
            2'b11: begin
                // On a tie without priority, serve whoever did not go last.
                if (CPU_PRIO != 0) winner = OWN_CPU;
                else               winner = (last_owner == OWN_CPU) ? OWN_EXT : OWN_CPU;
            end
            default: winner = OWN_CPU;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one unified instruction/data memory port between the CPU and an
// external requester, sequencing each access through WAIT_STATES wait cycles.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_STATES = 1,
    parameter int CPU_PRIO    = 0
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output state_t              dbg_state
);

    state_t            state;
    state_t            state_n;
    owner_t            owner_q;
    owner_t            last_owner;
    owner_t            winner;
    logic              we_q;
    logic [AW-1:0]     adr_q;
    logic [DW-1:0]     wd_q;
    logic [CNT_W-1:0]  cnt;
    logic [DW-1:0]     rd_q;
    logic [1:0]        req;
    logic              latch;
    logic              final_cyc;

    assign req = {bus.ext_req, bus.cpu_req};

    arb_pick2 #(
        .CPU_PRIO (CPU_PRIO)
    ) u_pick (
        .req        (req),
        .last_owner (last_owner),
        .winner     (winner)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        latch     = 1'b0;
        final_cyc = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    latch   = 1'b1;
                    state_n = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt == '0) begin
                    final_cyc = 1'b1;
                    state_n   = ST_RESP;
                end
            end
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Request fields are captured once at grant; the requester may change them freely afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q    <= OWN_CPU;
            we_q       <= 1'b0;
            adr_q      <= '0;
            wd_q       <= '0;
            cnt        <= '0;
            rd_q       <= '0;
            last_owner <= OWN_EXT;
        end else begin
            if (latch) begin
                owner_q <= winner;
                we_q    <= (winner == OWN_EXT) ? bus.ext_we  : bus.cpu_we;
                adr_q   <= (winner == OWN_EXT) ? bus.ext_adr : bus.cpu_adr;
                wd_q    <= (winner == OWN_EXT) ? bus.ext_wd  : bus.cpu_wd;
                cnt     <= CNT_W'(WAIT_STATES);
            end else if (state == ST_ACCESS && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (final_cyc && !we_q) rd_q <= bus.mem_rd;
            if (state == ST_RESP)   last_owner <= owner_q;
        end
    end

    // Strobe and ready decode from the state register, so reset clears them without a clock.
    assign bus.mem_adr   = adr_q;
    assign bus.mem_wd    = wd_q;
    assign bus.mem_we    = final_cyc & we_q;
    assign bus.cpu_rd    = rd_q;
    assign bus.ext_rd    = rd_q;
    assign bus.cpu_ready = (state == ST_RESP) && (owner_q == OWN_CPU);
    assign bus.ext_ready = (state == ST_RESP) && (owner_q == OWN_EXT);
    assign bus.grant_ext = ((state == ST_ACCESS) || (state == ST_RESP)) && (owner_q == OWN_EXT);
    assign dbg_state     = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: four instances cover the tie policies
// and wait-state settings; a negedge monitor checks every ready and write strobe.
module tb_mem_port_arbiter;
    import arb_pkg::*;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_pass;

    // Entries: {owner, rd, cycle} and {adr, wd, cycle}
    logic [64:0] exp_q  [4][$];
    logic [95:0] wexp_q [4][$];

    state_t dbg_a, dbg_b, dbg_c, dbg_d;

    mem_port_arbiter_if #(.AW(32), .DW(32)) ifa ();
    mem_port_arbiter_if #(.AW(32), .DW(32)) ifb ();
    mem_port_arbiter_if #(.AW(32), .DW(32)) ifc ();
    mem_port_arbiter_if #(.AW(32), .DW(32)) ifd ();

    mem_port_arbiter #(.AW(32), .DW(32), .WAIT_STATES(1), .CPU_PRIO(0)) dut_a (
        .clk(clk), .reset(rst_n), .bus(ifa), .dbg_state(dbg_a));
    mem_port_arbiter #(.AW(32), .DW(32), .WAIT_STATES(1), .CPU_PRIO(1)) dut_b (
        .clk(clk), .reset(rst_n), .bus(ifb), .dbg_state(dbg_b));
    mem_port_arbiter #(.AW(32), .DW(32), .WAIT_STATES(0), .CPU_PRIO(0)) dut_c (
        .clk(clk), .reset(rst_n), .bus(ifc), .dbg_state(dbg_c));
    mem_port_arbiter #(.AW(32), .DW(32), .WAIT_STATES(3), .CPU_PRIO(0)) dut_d (
        .clk(clk), .reset(rst_n), .bus(ifd), .dbg_state(dbg_d));

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h20) return 32'hE3A0_2005;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign ifa.mem_rd = mem_fn(ifa.mem_adr);
    assign ifb.mem_rd = mem_fn(ifb.mem_adr);
    assign ifc.mem_rd = mem_fn(ifc.mem_adr);
    assign ifd.mem_rd = mem_fn(ifd.mem_adr);

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL timeout: run did not finish within 100000 time units");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, got, exp, cyc);
    endtask

    // Driver tasks
    task automatic set_cpu(input int id, input logic req, input logic we,
                           input logic [31:0] adr, input logic [31:0] wd);
        case (id)
            0: begin ifa.cpu_req = req; ifa.cpu_we = we; ifa.cpu_adr = adr; ifa.cpu_wd = wd; end
            1: begin ifb.cpu_req = req; ifb.cpu_we = we; ifb.cpu_adr = adr; ifb.cpu_wd = wd; end
            2: begin ifc.cpu_req = req; ifc.cpu_we = we; ifc.cpu_adr = adr; ifc.cpu_wd = wd; end
            default: begin ifd.cpu_req = req; ifd.cpu_we = we; ifd.cpu_adr = adr; ifd.cpu_wd = wd; end
        endcase
    endtask

    task automatic set_ext(input int id, input logic req, input logic we,
                           input logic [31:0] adr, input logic [31:0] wd);
        case (id)
            0: begin ifa.ext_req = req; ifa.ext_we = we; ifa.ext_adr = adr; ifa.ext_wd = wd; end
            1: begin ifb.ext_req = req; ifb.ext_we = we; ifb.ext_adr = adr; ifb.ext_wd = wd; end
            2: begin ifc.ext_req = req; ifc.ext_we = we; ifc.ext_adr = adr; ifc.ext_wd = wd; end
            default: begin ifd.ext_req = req; ifd.ext_we = we; ifd.ext_adr = adr; ifd.ext_wd = wd; end
        endcase
    endtask

    task automatic push_rsp(input int id, input logic owner, input logic [31:0] rd, input int at);
        exp_q[id].push_back({owner, rd, 32'(at)});
    endtask

    // Scoreboard monitor
    task automatic mon(input int id, input logic cr, input logic er,
                       input logic [31:0] crd, input logic [31:0] erd,
                       input logic we, input logic [31:0] madr, input logic [31:0] mwd);
        logic [64:0] e;
        logic [95:0] w;
        if (cr || er) begin
            check($sformatf("ready_excl[%0d]", id), 32'(cr & er), 32'd0);
            if (exp_q[id].size() == 0) begin
                check($sformatf("spurious_ready[%0d]", id), 32'(exp_q[id].size()), 32'd1);
            end else begin
                e = exp_q[id].pop_front();
                check($sformatf("owner[%0d]", id), 32'(er), 32'(e[64]));
                check($sformatf("rd[%0d]", id), er ? erd : crd, e[63:32]);
                check($sformatf("ready_cycle[%0d]", id), 32'(cyc), e[31:0]);
            end
        end
        if (we) begin
            if (wexp_q[id].size() == 0) begin
                check($sformatf("spurious_write[%0d]", id), 32'(wexp_q[id].size()), 32'd1);
            end else begin
                w = wexp_q[id].pop_front();
                check($sformatf("wr_adr[%0d]", id), madr, w[95:64]);
                check($sformatf("wr_data[%0d]", id), mwd, w[63:32]);
                check($sformatf("wr_cycle[%0d]", id), 32'(cyc), w[31:0]);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, ifa.cpu_ready, ifa.ext_ready, ifa.cpu_rd, ifa.ext_rd, ifa.mem_we, ifa.mem_adr, ifa.mem_wd);
        mon(1, ifb.cpu_ready, ifb.ext_ready, ifb.cpu_rd, ifb.ext_rd, ifb.mem_we, ifb.mem_adr, ifb.mem_wd);
        mon(2, ifc.cpu_ready, ifc.ext_ready, ifc.cpu_rd, ifc.ext_rd, ifc.mem_we, ifc.mem_adr, ifc.mem_wd);
        mon(3, ifd.cpu_ready, ifd.ext_ready, ifd.cpu_rd, ifd.ext_rd, ifd.mem_we, ifd.mem_adr, ifd.mem_wd);
    end

    // Stimulus
    initial begin
        int k;
        int gcount;
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_cpu(i, 1'b0, 1'b0, 32'h0, 32'h0);
            set_ext(i, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_flags_a", {28'h0, ifa.cpu_ready, ifa.ext_ready, ifa.grant_ext, ifa.mem_we}, 32'h0);
        check("rst_cpu_rd_a", ifa.cpu_rd, 32'h0);
        check("rst_ext_rd_a", ifa.ext_rd, 32'h0);
        check("rst_mem_adr_a", ifa.mem_adr, 32'h0);
        check("rst_mem_wd_a", ifa.mem_wd, 32'h0);
        check("rst_state_a", 32'(dbg_a), 32'(ST_IDLE));
        check("rst_flags_b", {28'h0, ifb.cpu_ready, ifb.ext_ready, ifb.grant_ext, ifb.mem_we}, 32'h0);
        check("rst_flags_c", {28'h0, ifc.cpu_ready, ifc.ext_ready, ifc.grant_ext, ifc.mem_we}, 32'h0);
        check("rst_flags_d", {28'h0, ifd.cpu_ready, ifd.ext_ready, ifd.grant_ext, ifd.mem_we}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // CPU read at 0x20, req dropped right after grant
        k = cyc;
        set_cpu(0, 1'b1, 1'b0, 32'h20, 32'h0);
        push_rsp(0, OWN_CPU, 32'hE3A0_2005, k + 3);
        @(posedge clk); #1;
        set_cpu(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk); #1;

        // CPU write 0x54 <= 0xA; rd keeps the previous read value
        k = cyc;
        set_cpu(0, 1'b1, 1'b1, 32'h54, 32'h0000_000A);
        wexp_q[0].push_back({32'h54, 32'h0000_000A, 32'(k + 2)});
        push_rsp(0, OWN_CPU, 32'hE3A0_2005, k + 3);
        repeat (4) @(posedge clk); #1;
        set_cpu(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;

        // Round-robin with both requests held from reset release
        rst_n = 1'b0;
        set_cpu(0, 1'b1, 1'b0, 32'h100, 32'h0);
        set_ext(0, 1'b1, 1'b0, 32'h200, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        k = cyc;
        push_rsp(0, OWN_CPU, 32'h0100_FEFF, k + 3);
        push_rsp(0, OWN_EXT, 32'h0200_FDFF, k + 7);
        push_rsp(0, OWN_CPU, 32'h0100_FEFF, k + 11);
        push_rsp(0, OWN_EXT, 32'h0200_FDFF, k + 15);
        repeat (16) @(posedge clk); #1;
        set_cpu(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_ext(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk); #1;

        // Reset in the final ACCESS cycle of an EXT write
        set_ext(0, 1'b1, 1'b1, 32'h300, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        set_ext(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        check("pre_rst_mem_we", 32'(ifa.mem_we), 32'd1);
        check("pre_rst_grant_ext", 32'(ifa.grant_ext), 32'd1);
        check("pre_rst_mem_adr", ifa.mem_adr, 32'h300);
        check("pre_rst_mem_wd", ifa.mem_wd, 32'hDEAD_BEEF);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_mem_we", 32'(ifa.mem_we), 32'd0);
        check("mid_rst_ext_ready", 32'(ifa.ext_ready), 32'd0);
        check("mid_rst_grant_ext", 32'(ifa.grant_ext), 32'd0);
        check("mid_rst_state", 32'(dbg_a), 32'(ST_IDLE));
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("post_rst_cpu_rd", ifa.cpu_rd, 32'h0);
        k = cyc;
        set_cpu(0, 1'b1, 1'b0, 32'h400, 32'h0);
        set_ext(0, 1'b1, 1'b0, 32'h500, 32'h0);
        push_rsp(0, OWN_CPU, 32'h0400_FBFF, k + 3);
        push_rsp(0, OWN_EXT, 32'h0500_FAFF, k + 7);
        repeat (8) @(posedge clk); #1;
        set_cpu(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_ext(0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Fixed CPU priority: three CPU grants, then EXT once CPU lets go
        k = cyc;
        set_cpu(1, 1'b1, 1'b0, 32'h600, 32'h0);
        set_ext(1, 1'b1, 1'b0, 32'h700, 32'h0);
        push_rsp(1, OWN_CPU, 32'h0600_F9FF, k + 3);
        push_rsp(1, OWN_CPU, 32'h0600_F9FF, k + 7);
        push_rsp(1, OWN_CPU, 32'h0600_F9FF, k + 11);
        push_rsp(1, OWN_EXT, 32'h0700_F8FF, k + 15);
        gcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            gcount += int'(ifb.grant_ext);
        end
        check("prio_grant_ext_cycles", 32'(gcount), 32'd0);
        @(posedge clk); #1;
        set_cpu(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) @(posedge clk); #1;
        set_ext(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // WAIT_STATES = 0: ready two cycles after the request
        k = cyc;
        set_cpu(2, 1'b1, 1'b0, 32'h20, 32'h0);
        push_rsp(2, OWN_CPU, 32'hE3A0_2005, k + 2);
        repeat (3) @(posedge clk); #1;
        set_cpu(2, 1'b0, 1'b0, 32'h0, 32'h0);

        // WAIT_STATES = 3: ready five cycles after, address held for four cycles
        k = cyc;
        set_cpu(3, 1'b1, 1'b0, 32'h44, 32'h0);
        push_rsp(3, OWN_CPU, 32'h0044_FFBB, k + 5);
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("ws3_mem_adr_c%0d", i), ifd.mem_adr, 32'h44);
        end
        @(posedge clk);
        @(posedge clk); #1;
        set_cpu(3, 1'b0, 1'b0, 32'h0, 32'h0);

        repeat (4) @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rsp_left[%0d]", i), 32'(exp_q[i].size()), 32'd0);
            check($sformatf("wr_left[%0d]", i), 32'(wexp_q[i].size()), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
